// File: rtl/ex_mdu_pkg.sv
// Shared opcodes, result-class selects and divider state encoding for the EX stage.
package ex_mdu_pkg;

  localparam int unsigned ALUOP_W   = 8;
  localparam int unsigned ALUSEL_W  = 3;
  localparam int unsigned REGADDR_W = 5;

  // Reset is asserted low throughout this pipeline.
  localparam logic RST_ENABLE = 1'b0;

  // Operation codes carried in aluop_i.
  localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [ALUOP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

  // Result class carried in alusel_i.
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;

  // Iterative divider states.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ZERO = 2'b01,
    DIV_ON   = 2'b10,
    DIV_END  = 2'b11
  } div_state_e;

  // True for either divide flavour.
  function automatic logic is_div_op(input logic [ALUOP_W-1:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring iterative divider: one quotient bit per cycle, signed fix-up on completion.
module div_iter
  import ex_mdu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_signed,
  input  logic              flush,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy_c,
  output logic              ready_c,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  div_state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] work_q;   // dividend bits shift out as quotient bits shift in
  logic [DATA_W-1:0] dvs_q;
  logic [DATA_W-1:0] rem_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rmd_q;

  logic              divisor_zero;
  logic [DATA_W-1:0] dvd_mag;
  logic [DATA_W-1:0] dvs_mag;
  logic [DATA_W:0]   partial;
  logic [DATA_W:0]   trial;
  logic              no_borrow;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W-1:0] quo_step;
  logic              last_step;

  // Operand magnitudes for the unsigned core; DIVU passes operands through.
  always_comb begin
    divisor_zero = (divisor == '0);
    dvd_mag      = (is_signed && dividend[DATA_W-1]) ? -dividend : dividend;
    dvs_mag      = (is_signed && divisor[DATA_W-1])  ? -divisor  : divisor;
  end

  // One shift-subtract step; a quotient bit is set when the subtraction does not borrow.
  always_comb begin
    partial   = {rem_q, work_q[DATA_W-1]};
    trial     = partial - {1'b0, dvs_q};
    no_borrow = ~trial[DATA_W];
    rem_step  = no_borrow ? trial[DATA_W-1:0] : partial[DATA_W-1:0];
    quo_step  = {work_q[DATA_W-2:0], no_borrow};
    last_step = (cnt_q == CNT_W'(DATA_W - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus stall/ready strobes; a flush always wins.
  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    ready_c = 1'b0;
    if (flush) begin
      state_d = DIV_IDLE;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (start) begin
            busy_c  = 1'b1;
            state_d = divisor_zero ? DIV_ZERO : DIV_ON;
          end
        end
        DIV_ZERO: begin
          busy_c  = 1'b1;
          state_d = DIV_END;
        end
        DIV_ON: begin
          busy_c = 1'b1;
          if (last_step) begin
            state_d = DIV_END;
          end
        end
        DIV_END: begin
          ready_c = 1'b1;
          state_d = DIV_IDLE;
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  // Operand capture, iteration and final sign-corrected result.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      cnt_q     <= '0;
      work_q    <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rmd_q     <= '0;
    end else if (!flush) begin
      unique case (state_q)
        DIV_IDLE: begin
          if (start && !divisor_zero) begin
            work_q    <= dvd_mag;
            dvs_q     <= dvs_mag;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= is_signed && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            neg_rem_q <= is_signed && dividend[DATA_W-1];
          end
        end
        DIV_ZERO: begin
          quo_q <= '1;
          rmd_q <= dividend;
        end
        DIV_ON: begin
          work_q <= quo_step;
          rem_q  <= rem_step;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_step) begin
            quo_q <= neg_quo_q ? -quo_step : quo_step;
            rmd_q <= neg_rem_q ? -rem_step : rem_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = quo_q;
  assign remainder = rmd_q;

endmodule

// File: rtl/ex_mdu.sv
// MIPS32 execute stage: single-cycle logic/shift results plus a stalling iterative divider.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ALUOP_W-1:0]   aluop_i,
  input  logic [ALUSEL_W-1:0]  alusel_i,
  input  logic [DATA_W-1:0]    reg1_i,
  input  logic [DATA_W-1:0]    reg2_i,
  input  logic [REGADDR_W-1:0] wd_i,
  input  logic                 wreg_i,
  input  logic                 flush_i,
  output logic [REGADDR_W-1:0] wd_o,
  output logic                 wreg_o,
  output logic [DATA_W-1:0]    wdata_o,
  output logic                 whilo_o,
  output logic [DATA_W-1:0]    hi_o,
  output logic [DATA_W-1:0]    lo_o,
  output logic                 stallreq_o
);

  localparam int unsigned SHAMT_W = $clog2(DATA_W);

  logic               rst_off;
  logic               is_div;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  logic_res;
  logic [DATA_W-1:0]  shift_res;
  logic [DATA_W-1:0]  result;
  logic               div_busy;
  logic               div_ready;
  logic [DATA_W-1:0]  div_quo;
  logic [DATA_W-1:0]  div_rem;

  assign rst_off = (rst != RST_ENABLE);
  assign is_div  = is_div_op(aluop_i);
  assign shamt   = reg1_i[SHAMT_W-1:0];

  // Bitwise logic class.
  always_comb begin
    logic_res = '0;
    unique case (aluop_i)
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      default:    logic_res = '0;
    endcase
  end

  // Shift class: reg2_i is shifted by the low bits of reg1_i.
  always_comb begin
    shift_res = '0;
    unique case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << shamt;
      EXE_SRL_OP: shift_res = reg2_i >> shamt;
      EXE_SRA_OP: shift_res = $unsigned($signed(reg2_i) >>> shamt);
      default:    shift_res = '0;
    endcase
  end

  // Result-class select for the GPR write data.
  always_comb begin
    result = '0;
    unique case (alusel_i)
      EXE_RES_LOGIC: result = logic_res;
      EXE_RES_SHIFT: result = shift_res;
      EXE_RES_NOP:   result = '0;
      default:       result = '0;
    endcase
  end

  div_iter #(
    .DATA_W (DATA_W)
  ) u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div),
    .is_signed (aluop_i == EXE_DIV_OP),
    .flush     (flush_i),
    .dividend  (reg1_i),
    .divisor   (reg2_i),
    .busy_c    (div_busy),
    .ready_c   (div_ready),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Everything reads as zero while reset is held.
  assign wd_o       = rst_off ? wd_i : '0;
  assign wreg_o     = rst_off & wreg_i;
  assign wdata_o    = rst_off ? result : '0;
  assign whilo_o    = rst_off & is_div & div_ready;
  assign hi_o       = whilo_o ? div_rem : '0;
  assign lo_o       = whilo_o ? div_quo : '0;
  assign stallreq_o = rst_off & div_busy;

endmodule

// File: tb/tb_ex_mdu.sv
// Bench for ex_mdu: vector table for the single-cycle path, scripted and random divides.
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [4:0]  wd;
  logic        wreg;
  logic        flush;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  int n_total = 0;
  int n_pass  = 0;

  ex_mdu #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop),
    .alusel_i   (alusel),
    .reg1_i     (reg1),
    .reg2_i     (reg2),
    .wd_i       (wd),
    .wreg_i     (wreg),
    .flush_i    (flush),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .whilo_o    (whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stallreq_o (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string nm, input logic [7:0] op, input logic [2:0] sel,
                              input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] ex);
    vec_t v;
    v.name = nm; v.op = op; v.sel = sel; v.r1 = r1; v.r2 = r2; v.exp = ex;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference for the single-cycle path, from the instruction semantics.
  function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [2:0] sel,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int s;
    s = int'(a[4:0]);
    r = 32'h0;
    if (sel == EXE_RES_LOGIC) begin
      if (op == EXE_OR_OP)       r = a | b;
      else if (op == EXE_AND_OP) r = a & b;
      else if (op == EXE_XOR_OP) r = a ^ b;
      else if (op == EXE_NOR_OP) r = ~(a | b);
    end else if (sel == EXE_RES_SHIFT) begin
      if (op == EXE_SLL_OP)      r = b << s;
      else if (op == EXE_SRL_OP) r = b >> s;
      else if (op == EXE_SRA_OP) begin
        r = b >> s;
        if (b[31]) for (int i = 0; i < s; i++) r[31 - i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Reference divide: truncating quotient, remainder takes the dividend's sign.
  task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!sgn) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'h0;
    end else begin
      q = 32'(sa / sb); r = 32'(sa % sb);
    end
  endtask

  // Issue a divide at the current cycle, count stall cycles, then check the END cycle.
  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input string nm);
    int n;
    logic saw;
    int exp_stall;
    exp_stall = (b == 32'h0) ? 2 : 33;
    aluop = op; alusel = EXE_RES_NOP; reg1 = a; reg2 = b; flush = 1'b0;
    #1;
    n = 0;
    saw = 1'b0;
    while (stallreq_o === 1'b1 && n < 100) begin
      if (whilo_o !== 1'b0) saw = 1'b1;
      n++;
      next_cycle();
    end
    check({nm, " stall_cycles"}, 32'(n), 32'(exp_stall));
    check({nm, " early_whilo"}, 32'(saw), 32'h0);
    check({nm, " whilo"}, 32'(whilo_o), 32'h1);
    check({nm, " lo"}, lo_o, eq);
    check({nm, " hi"}, hi_o, er);
  endtask

  task automatic check_idle(input string nm);
    next_cycle();
    aluop = EXE_NOP_OP;
    #1;
    check({nm, " idle_whilo"}, 32'(whilo_o), 32'h0);
    check({nm, " idle_stall"}, 32'(stallreq_o), 32'h0);
    check({nm, " idle_lo"}, lo_o, 32'h0);
  endtask

  initial begin
    logic [31:0] eq, er, a, b;
    logic [7:0]  op;
    logic [7:0]  ops [7];
    logic [2:0]  sels [3];
    vec_t v;

    ops  = '{EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP};
    sels = '{EXE_RES_LOGIC, EXE_RES_SHIFT, EXE_RES_NOP};

    vq.push_back(mk("or",        EXE_OR_OP,  EXE_RES_LOGIC, 32'h0F0F_0000, 32'h00FF_00FF, 32'h0FFF_00FF));
    vq.push_back(mk("and",       EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200));
    vq.push_back(mk("xor",       EXE_XOR_OP, EXE_RES_LOGIC, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555));
    vq.push_back(mk("nor",       EXE_NOR_OP, EXE_RES_LOGIC, 32'h0F0F_0000, 32'h00FF_00FF, 32'hF000_FF00));
    vq.push_back(mk("sra4",      EXE_SRA_OP, EXE_RES_SHIFT, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000));
    vq.push_back(mk("sra0",      EXE_SRA_OP, EXE_RES_SHIFT, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000));
    vq.push_back(mk("sra_hibit", EXE_SRA_OP, EXE_RES_SHIFT, 32'hFFFF_FFE4, 32'h8000_0000, 32'hF800_0000));
    vq.push_back(mk("sra31pos",  EXE_SRA_OP, EXE_RES_SHIFT, 32'h0000_001F, 32'h7FFF_FFFF, 32'h0000_0000));
    vq.push_back(mk("sll8",      EXE_SLL_OP, EXE_RES_SHIFT, 32'h0000_0008, 32'h1234_5678, 32'h3456_7800));
    vq.push_back(mk("srl31",     EXE_SRL_OP, EXE_RES_SHIFT, 32'h0000_001F, 32'h8000_0001, 32'h0000_0001));
    vq.push_back(mk("sel_nop",   EXE_OR_OP,  EXE_RES_NOP,   32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000));
    vq.push_back(mk("bad_op",    8'hFF,      EXE_RES_LOGIC, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000));
    vq.push_back(mk("cls_mix",   EXE_SLL_OP, EXE_RES_LOGIC, 32'h0000_0001, 32'h1234_5678, 32'h0000_0000));

    // Reset held: outputs forced to zero even with live inputs.
    rst = 1'b0; flush = 1'b0;
    aluop = EXE_DIVU_OP; alusel = EXE_RES_LOGIC;
    reg1 = 32'h0000_0064; reg2 = 32'h0000_0007; wd = 5'd7; wreg = 1'b1;
    #2;
    check("rst wd_o", 32'(wd_o), 32'h0);
    check("rst wreg_o", 32'(wreg_o), 32'h0);
    check("rst stallreq", 32'(stallreq_o), 32'h0);
    check("rst whilo", 32'(whilo_o), 32'h0);
    check("rst hi", hi_o, 32'h0);
    aluop = EXE_NOP_OP;
    #5;
    rst = 1'b1;
    next_cycle();

    // Single-cycle table.
    foreach (vq[i]) begin
      v = vq[i];
      aluop = v.op; alusel = v.sel; reg1 = v.r1; reg2 = v.r2;
      wd = 5'(i + 3); wreg = i[0];
      #1;
      check({v.name, " wdata"}, wdata_o, v.exp);
      check({v.name, " wd_o"}, 32'(wd_o), 32'(i + 3));
      check({v.name, " wreg_o"}, 32'(wreg_o), 32'(i[0]));
      check({v.name, " stall"}, 32'(stallreq_o), 32'h0);
      check({v.name, " whilo"}, 32'(whilo_o), 32'h0);
      next_cycle();
    end

    // Scripted divides, including back-to-back issue after END.
    run_div(EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 32'd2, "divu_100_7");
    next_cycle();
    run_div(EXE_DIV_OP, -32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2");
    next_cycle();
    run_div(EXE_DIV_OP, 32'd7, -32'sd2, 32'hFFFF_FFFD, 32'h0000_0001, "div_7_m2");
    next_cycle();
    run_div(EXE_DIVU_OP, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, "divu_5_0");
    next_cycle();
    run_div(EXE_DIV_OP, -32'sd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "div_m5_0");
    next_cycle();
    run_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, "div_min_m1");
    next_cycle();
    run_div(EXE_DIVU_OP, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, "divu_max_1");
    check_idle("post_div");

    // Flush in the issue cycle suppresses the stall request.
    next_cycle();
    aluop = EXE_DIVU_OP; alusel = EXE_RES_NOP; reg1 = 32'd1000; reg2 = 32'd3; flush = 1'b1;
    #1;
    check("flush_issue stall", 32'(stallreq_o), 32'h0);
    next_cycle();
    flush = 1'b0;

    // Flush at step 10 of a divide, then a fresh divide completes.
    #1;
    for (int i = 0; i < 9; i++) next_cycle();
    check("pre_flush stall", 32'(stallreq_o), 32'h1);
    flush = 1'b1;
    #1;
    check("flush stall", 32'(stallreq_o), 32'h0);
    check("flush whilo", 32'(whilo_o), 32'h0);
    next_cycle();
    flush = 1'b0;
    run_div(EXE_DIVU_OP, 32'd1000, 32'd3, 32'd333, 32'd1, "after_flush");
    check_idle("after_flush");

    // Asynchronous reset mid-divide.
    next_cycle();
    aluop = EXE_DIV_OP; alusel = EXE_RES_NOP; reg1 = -32'sd50; reg2 = 32'd7; wd = 5'd9; wreg = 1'b1;
    for (int i = 0; i < 5; i++) next_cycle();
    #2;
    rst = 1'b0;
    #1;
    check("arst stall", 32'(stallreq_o), 32'h0);
    check("arst whilo", 32'(whilo_o), 32'h0);
    check("arst hi", hi_o, 32'h0);
    check("arst lo", lo_o, 32'h0);
    check("arst wd_o", 32'(wd_o), 32'h0);
    check("arst wreg_o", 32'(wreg_o), 32'h0);
    aluop = EXE_NOP_OP;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    run_div(EXE_DIV_OP, -32'sd50, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "after_rst");

    // Random divides issued back-to-back.
    for (int k = 0; k < 30; k++) begin
      next_cycle();
      op = ($urandom_range(0, 1) == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1, 2:    b = 32'($urandom_range(1, 16));
        3:       b = -32'($urandom_range(1, 16));
        default: b = $urandom;
      endcase
      ref_div(op == EXE_DIV_OP, a, b, eq, er);
      run_div(op, a, b, eq, er, $sformatf("rnd%0d", k));
    end
    check_idle("rnd_end");

    // Random single-cycle operations.
    for (int k = 0; k < 40; k++) begin
      next_cycle();
      aluop  = ops[$urandom_range(0, 6)];
      alusel = sels[$urandom_range(0, 2)];
      reg1   = $urandom;
      reg2   = $urandom;
      #1;
      check($sformatf("rnd_alu%0d", k), wdata_o, ref_alu(aluop, alusel, reg1, reg2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
Next-generation execute stage for the 5-stage MIPS32 pipeline, sitting between the ID/EX and EX/MEM registers.
- Keeps single-cycle logic (OR/AND/NOR/XOR) and shift (SLL/SRL/SRA) results, generalised to DATA_W bits.
- Adds a multi-cycle iterative divider (DIV/DIVU) that writes HI/LO.
- Raises a stall request to the pipeline controller while a divide is in flight.

Parameters:
- DATA_W, 32, datapath width; must be a power of two, at least 8.
- SHAMT_W, log2(DATA_W), number of reg1_i LSBs used as the shift amount.
- ALUOP_W, 8, aluop_i width.
- ALUSEL_W, 3, alusel_i width.
- REGADDR_W, 5, destination register address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- aluop_i  in  ALUOP_W  operation code from ID/EX.
- alusel_i  in  ALUSEL_W  result class from ID/EX (LOGIC, SHIFT, NOP).
- reg1_i  in  DATA_W  operand 1 (shift amount for shifts, dividend for divides).
- reg2_i  in  DATA_W  operand 2 (shifted value for shifts, divisor for divides).
- wd_i  in  REGADDR_W  destination register address.
- wreg_i  in  1  GPR write enable.
- flush_i  in  1  annul the instruction currently in EX.
- wd_o  out  REGADDR_W  forwarded wd_i.
- wreg_o  out  1  forwarded wreg_i.
- wdata_o  out  DATA_W  GPR write data.
- whilo_o  out  1  HI/LO write strobe.
- hi_o  out  DATA_W  remainder.
- lo_o  out  DATA_W  quotient.
- stallreq_o  out  1  request to stall the PC/IF/ID/EX stages.

Behaviour:
Reset:
- rst low clears the FSM to IDLE and all divider registers to 0 immediately (asynchronous).
- While rst is low, every output is 0.

Single-cycle path (combinational, 0 latency):
- wd_o = wd_i and wreg_o = wreg_i, always.
- LOGIC ops are bitwise on DATA_W bits.
- SLL/SRL shift reg2_i by reg1_i[SHAMT_W-1:0].
- SRA is an arithmetic shift that replicates the sign bit; shift amount 0 returns reg2_i unchanged.
- alusel_i = LOGIC selects the logic result, SHIFT selects the shift result; any other value gives wdata_o = 0.
- An unknown aluop_i gives a 0 result for its class.

Divider FSM, states IDLE, DIVZERO, ON, END:
- IDLE: aluop_i = DIV or DIVU and flush_i = 0 ->
  - divisor == 0: go to DIVZERO.
  - otherwise: go to ON, latch |dividend| and |divisor| (DIVU: raw values), clear the remainder, and clear the iteration counter.
- DIVZERO: hold 1 cycle, then END.
  - Result: quotient all-ones, remainder = dividend.
- ON: one restoring-division step per cycle (shift-subtract, quotient bit = no-borrow).
  - After DATA_W steps go to END.
  - For signed DIV: negate the quotient if the operand signs differ; give the remainder the dividend's sign.
- END: lo_o = quotient, hi_o = remainder, whilo_o = 1, stallreq_o = 0. Next state is IDLE.
- stallreq_o is 1 in IDLE when a divide is being started, and in DIVZERO and ON. It is 0 otherwise.
- Stall duration:
  - Nonzero divisor: exactly DATA_W+1 stall cycles; the result appears in cycle DATA_W+2 after issue.
  - Zero divisor: 2 stall cycles.
- The controller holds ID/EX inputs stable while stallreq_o = 1. The block does not re-latch operands mid-divide.
- Back-to-back divides: END -> IDLE, and the next divide starts in the cycle after END. There is no overlap.
- flush_i = 1 in any state forces IDLE at the next edge. Combinationally, it forces stallreq_o = 0 and whilo_o = 0 in that cycle.
- A non-divide aluop_i gives whilo_o = 0, and hi_o/lo_o = 0.

Decomposition:
- Shared package/define file holds:
  - EXE_*_OP codes (adding EXE_DIV_OP, EXE_DIVU_OP).
  - EXE_RES_* select codes.
  - Divider state encodings.
  - RstEnable redefined as 1'b0.
- Natural sub-module: div_iter.
  - Contains the FSM, operand registers, counter, and sign fix-up.
  - Handshake: start/signed/flush in; ready/result out.
- ex_mdu instantiates div_iter and keeps the combinational logic/shift muxes.

Test Plan:
- DATA_W=32, OR 0x0F0F0000 | 0x00FF00FF, alusel=LOGIC -> wdata_o=0x0FFF00FF same cycle; stallreq_o=0; whilo_o=0.
- SRA reg2=0x80000000, reg1=4 -> 0xF8000000; shift amount 0 -> 0x80000000; reg1=0xFFFFFFE4 -> uses 4 -> same result.
- DIVU 100/7 -> stallreq_o high 33 cycles; then lo_o=14, hi_o=2, whilo_o=1 for 1 cycle.
- DIV -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIV 7/-2 -> lo_o=0xFFFFFFFD, hi_o=1.
- DIVU 5/0 -> 2 stall cycles, then lo_o=0xFFFFFFFF, hi_o=5.
- Start DIVU; flush_i at step 10 -> stallreq_o=0 immediately, no whilo_o pulse; a new divide completes correctly. Repeat with rst low mid-divide -> all outputs 0 asynchronously.
